// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two-requester front end to a single-cycle ALU. A round-robin arbiter picks
// one requester per cycle, the ALU result is registered one cycle later, and
// the registered result is held while the consumer stalls (res_rdy low).
//
// Build option:
//   ALU_CC_EN  - when defined, a condition-code register {ZF, SF, OF} is kept
//                and updated on every edge that registers a valid-opcode
//                result. When undefined, cc is tied to 3'b000 and no cc flops
//                exist.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   req0/req1        operation requests
//   ifun0/ifun1      opcodes: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4..15 invalid
//   a0,b0,a1,b1      operands (valA, valB)
//   gnt0/gnt1        combinational grant, operation accepted on this edge
//   res              registered result
//   res_vld          result valid
//   res_id           requester that owns res
//   res_rdy          result consumer ready
//   err              registered invalid-opcode flag
//   cc               condition codes {ZF, SF, OF}
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [3:0]   ifun0,
    input  logic [3:0]   ifun1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [W-1:0] res,
    output logic         res_vld,
    output logic         res_id,
    input  logic         res_rdy,
    output logic         err,
    output logic [2:0]   cc
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;

    logic [W-1:0] res_q, res_d;
    logic         vld_q;
    logic         id_q;
    logic         err_q;
    // rr_q = 0: requester 0 wins a tie; rr_q = 1: requester 1 wins a tie
    logic         rr_q, rr_d;

    logic         can_grant;
    logic         any_gnt;
    logic [3:0]   sel_fun;
    logic [W-1:0] sel_a, sel_b;
    logic         op_ok;

    // ------------------------------------------------------------------
    // Arbitration: no grant in reset or while the held result is stalled
    // ------------------------------------------------------------------
    assign can_grant = !rst && !(vld_q && !res_rdy);
    assign gnt0      = can_grant && req0 && (!req1 || !rr_q);
    assign gnt1      = can_grant && req1 && (!req0 ||  rr_q);
    assign any_gnt   = gnt0 || gnt1;

    always_comb begin
        rr_d = rr_q;
        if (gnt0) rr_d = 1'b1;
        if (gnt1) rr_d = 1'b0;
    end

    // ------------------------------------------------------------------
    // ALU on the granted requester's operands
    // ------------------------------------------------------------------
    assign sel_fun = gnt1 ? ifun1 : ifun0;
    assign sel_a   = gnt1 ? a1    : a0;
    assign sel_b   = gnt1 ? b1    : b0;

    always_comb begin
        res_d = '0;
        op_ok = 1'b1;
        case (sel_fun)
            OP_ADD:  res_d = sel_b + sel_a;
            OP_SUB:  res_d = sel_b - sel_a;
            OP_AND:  res_d = sel_b & sel_a;
            OP_XOR:  res_d = sel_b ^ sel_a;
            default: op_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register; holds while stalled, drops valid when drained idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
            id_q  <= 1'b0;
            err_q <= 1'b0;
            rr_q  <= 1'b0;
        end else begin
            rr_q <= rr_d;
            if (any_gnt) begin
                res_q <= res_d;
                vld_q <= 1'b1;
                id_q  <= gnt1;
                err_q <= !op_ok;
            end else if (res_rdy) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign res     = res_q;
    assign res_vld = vld_q;
    assign res_id  = id_q;
    assign err     = err_q;

`ifdef ALU_CC_EN
    logic [2:0] cc_q;
    logic       of_d;

    // Signed overflow: ADD overflows when like-signed operands give a result
    // of the other sign; SUB (b - a) when unlike signs flip b's sign.
    always_comb begin
        of_d = 1'b0;
        case (sel_fun)
            OP_ADD: of_d = (sel_a[W-1] == sel_b[W-1]) && (res_d[W-1] != sel_a[W-1]);
            OP_SUB: of_d = (sel_a[W-1] != sel_b[W-1]) && (res_d[W-1] != sel_b[W-1]);
            default: of_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= 3'b000;
        end else if (any_gnt && op_ok) begin
            cc_q <= {(res_d == '0), res_d[W-1], of_d};
        end
    end

    assign cc = cc_q;
`else
    assign cc = 3'b000;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [3:0]   ifun0, ifun1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1;
    logic [W-1:0] res;
    logic         res_vld, res_id;
    logic         res_rdy;
    logic         err;
    logic [2:0]   cc;

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .ifun0(ifun0), .ifun1(ifun1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .res(res), .res_vld(res_vld), .res_id(res_id),
        .res_rdy(res_rdy), .err(err), .cc(cc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [63:0] m_res = '0;
    logic        m_vld = 1'b0;
    logic        m_id  = 1'b0;
    logic        m_err = 1'b0;
    logic [2:0]  m_cc  = 3'b000;
    int          m_last = 1;   // index granted most recently; 1 => requester 0 wins ties
    int          m_g = -1;     // grant of the latest step (-1 none)

    // Signed overflow found by computing in one extra bit
    function automatic void ref_alu(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic e, output logic [2:0] c);
        logic [64:0] wide;
        logic ov;
        e = 1'b0; ov = 1'b0; r = '0;
        case (f)
            4'd0: begin wide = {a[63], a} + {b[63], b}; r = wide[63:0]; ov = wide[64] != wide[63]; end
            4'd1: begin wide = {b[63], b} - {a[63], a}; r = wide[63:0]; ov = wide[64] != wide[63]; end
            4'd2: r = b & a;
            4'd3: r = b ^ a;
            default: begin r = '0; e = 1'b1; end
        endcase
        c = {(r == 64'd0), r[63], ov};
    endfunction

    function automatic int exp_grant();
        if (rst || (m_vld && !res_rdy)) return -1;
        if (req0 && req1) return (m_last == 0) ? 1 : 0;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    // One clock: check grants before the edge, advance model, check registers after
    task automatic step();
        int g;
        logic [63:0] r;
        logic e;
        logic [2:0] c;
        #1;
        g = exp_grant();
        chk("gnt0", 64'(gnt0), 64'(g == 0));
        chk("gnt1", 64'(gnt1), 64'(g == 1));
        @(posedge clk);
        if (rst) begin
            m_res = '0; m_vld = 0; m_id = 0; m_err = 0; m_cc = 3'b000; m_last = 1;
        end else if (g >= 0) begin
            if (g == 0) ref_alu(ifun0, a0, b0, r, e, c);
            else        ref_alu(ifun1, a1, b1, r, e, c);
            m_res = r; m_err = e; m_vld = 1; m_id = g[0]; m_last = g;
`ifdef ALU_CC_EN
            if (!e) m_cc = c;
`endif
        end else if (res_rdy) begin
            m_vld = 0;
        end
        m_g = g;
        #1;
        chk("res", res, m_res);
        chk("res_vld", 64'(res_vld), 64'(m_vld));
        chk("res_id", 64'(res_id), 64'(m_id));
        chk("err", 64'(err), 64'(m_err));
        chk("cc", 64'(cc), 64'(m_cc));
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; ifun0 = 0; ifun1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rnd_fun();
        if ($urandom_range(0, 9) < 8) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(4, 15));
    endfunction

    logic [63:0] held;

    initial begin
        rst = 1; res_rdy = 1; idle();
        step(); step();
        chk("rst_res", res, 64'd0);
        chk("rst_vld", 64'(res_vld), 64'd0);
        rst = 0;
        step();

        // ADD 5 + 7 from requester 0
        req0 = 1; ifun0 = 4'd0; a0 = 64'd5; b0 = 64'd7;
        step();
        chk("add_res", res, 64'd12);
        chk("add_id", 64'(res_id), 64'd0);
        req0 = 0;
        step();

        // reset, then both requesters held: 0,1,0,1
        rst = 1; step(); rst = 0;
        req0 = 1; req1 = 1; ifun0 = 4'd2; a0 = 64'hF0F0; b0 = 64'hFF00;
        ifun1 = 4'd3; a1 = 64'h1234; b1 = 64'h00FF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_id", 64'(res_id), 64'(i % 2));
        end
        idle(); step();

        // SUB 1 - 1 -> zero; ADD max positive twice -> overflow
        req0 = 1; ifun0 = 4'd1; a0 = 64'd1; b0 = 64'd1;
        step();
        chk("sub_zero", res, 64'd0);
        ifun0 = 4'd0; a0 = 64'h7FFF_FFFF_FFFF_FFFF; b0 = 64'h7FFF_FFFF_FFFF_FFFF;
        step();
        chk("add_ovf", res, 64'hFFFF_FFFF_FFFF_FFFE);

        // invalid opcode right after: err, res 0, cc kept
        ifun0 = 4'd7;
        step();
        chk("inv_err", 64'(err), 64'd1);
        chk("inv_res", res, 64'd0);
        req0 = 0;

        // stall three cycles with req1 pending
        req1 = 1; ifun1 = 4'd0; a1 = 64'd100; b1 = 64'd23;
        res_rdy = 0;
        held = res;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_res", res, held);
        end
        res_rdy = 1;
        step();
        chk("unstall_res", res, 64'd123);
        req1 = 0;

        // reset while a result is valid and req0 is high
        req0 = 1; ifun0 = 4'd3; a0 = 64'h55; b0 = 64'hAA;
        step();
        rst = 1;
        step();
        chk("rst_drop_vld", 64'(res_vld), 64'd0);
        rst = 0; idle();
        step();

        // randomized traffic; a requester keeps its op until granted
        for (int n = 0; n < 3000; n++) begin
            if (!req0 || m_g == 0) begin
                req0 = ($urandom_range(0, 99) < 60);
                ifun0 = rnd_fun(); a0 = rnd_operand(); b0 = rnd_operand();
            end
            if (!req1 || m_g == 1) begin
                req1 = ($urandom_range(0, 99) < 60);
                ifun1 = rnd_fun(); a1 = rnd_operand(); b1 = rnd_operand();
            end
            res_rdy = ($urandom_range(0, 99) < 70);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
